upio_apb_ctrl: RTL and testbench

// - Parametrised successor to the fixed 8-bit user-plugin APB I/O slave: NUM_IO pins, per-pin direction/output,

---
 rtl/upio_apb_ctrl_pkg.sv | 29 ++
 rtl/upio_apb_ctrl_if.sv | 23 ++
 rtl/upio_apb_ctrl_debounce.sv | 29 ++
 rtl/upio_apb_ctrl.sv | 153 +++++++++++++++
 tb/tb_upio_apb_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/upio_apb_ctrl_pkg.sv
// Shared register map and types for the user-plugin APB I/O controller.
// Byte offsets are decoded on PADDR[5:2]; upio_reg_e is that word index.
package upio_pkg;

   localparam int MAX_IO = 32;

   localparam logic [7:0] UPIO_DIR      = 8'h00;
   localparam logic [7:0] UPIO_OUT      = 8'h04;
   localparam logic [7:0] UPIO_IN       = 8'h08;
   localparam logic [7:0] UPIO_RISE_EN  = 8'h0C;
   localparam logic [7:0] UPIO_FALL_EN  = 8'h10;
   localparam logic [7:0] UPIO_STATUS   = 8'h14;
   localparam logic [7:0] UPIO_SRC_MASK = 8'h18;
   localparam logic [7:0] UPIO_SRC_RAW  = 8'h1C;
   localparam logic [7:0] UPIO_DEBOUNCE = 8'h20;

   typedef enum logic [3:0] {
      REG_DIR      = 4'd0,
      REG_OUT      = 4'd1,
      REG_IN       = 4'd2,
      REG_RISE_EN  = 4'd3,
      REG_FALL_EN  = 4'd4,
      REG_STATUS   = 4'd5,
      REG_SRC_MASK = 4'd6,
      REG_SRC_RAW  = 4'd7,
      REG_DEBOUNCE = 4'd8
   } upio_reg_e;

endpackage

// File: rtl/upio_apb_ctrl_if.sv
// APB3 bus bundle for the user-plugin I/O controller.
interface upio_apb_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] PADDR;
   logic [31:0]       PWDATA;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic [31:0]       PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/upio_apb_ctrl_debounce.sv
// Per-pin debouncer: dout follows din only after din has differed for db_val+1 cycles.
// A db_val below the running count is reached only after the counter wraps.
module upio_debounce #(
   parameter int DB_CNT_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                din,
   input  logic [DB_CNT_W-1:0] db_val,
   output logic                dout
);

   logic [DB_CNT_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din == dout) begin
         cnt  <= '0;
      end else if (cnt == db_val) begin
         dout <= din;
         cnt  <= '0;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/upio_apb_ctrl.sv
// User-plugin APB I/O slave: NUM_IO pins with edge interrupts plus masked external sources.
// Define UPIO_DEBOUNCE_EN to add per-pin debouncers and the DEBOUNCE register at 0x20.
module upio_apb_ctrl
   import upio_pkg::*;
#(
   parameter int NUM_IO   = 8,
   parameter int NUM_SRC  = 2,
   parameter int ADDR_W   = 12,
   parameter int DB_CNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   upio_apb_if.slave          apb,
   input  logic [NUM_IO-1:0]  upio_in_i,
   output logic [NUM_IO-1:0]  upio_out_o,
   output logic [NUM_IO-1:0]  upio_dir_o,
   input  logic [NUM_SRC-1:0] src_int_i,
   output logic               int_o
);

   logic [ADDR_W-1:0]  paddr;
   logic [31:0]        pwdata;
   logic [3:0]         widx;
   upio_reg_e          reg_sel;
   logic               access, mapped, wr;
   logic               unused_bus;

   logic [NUM_IO-1:0]  dir_q, out_q, rise_en_q, fall_en_q, status_q;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_IO-1:0]  s1, s2, filt, prev;
   logic [NUM_IO-1:0]  rise, fall, ev, clr;
   logic [MAX_IO-1:0]  rdata;

   assign paddr      = apb.PADDR;
   assign pwdata     = apb.PWDATA;
   assign unused_bus = ^{paddr, pwdata};
   assign widx       = paddr[5:2];
   assign reg_sel    = upio_reg_e'(widx);
   assign access     = apb.PSEL & apb.PENABLE;

`ifdef UPIO_DEBOUNCE_EN
   assign mapped = (widx <= 4'd8);
`else
   assign mapped = (widx <= 4'd7);
`endif

   assign wr = access & apb.PWRITE & mapped;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q     <= '0;
         out_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         mask_q    <= '0;
      end else if (wr) begin
         case (reg_sel)
            REG_DIR:      dir_q     <= pwdata[NUM_IO-1:0];
            REG_OUT:      out_q     <= pwdata[NUM_IO-1:0];
            REG_RISE_EN:  rise_en_q <= pwdata[NUM_IO-1:0];
            REG_FALL_EN:  fall_en_q <= pwdata[NUM_IO-1:0];
            REG_SRC_MASK: mask_q    <= pwdata[NUM_SRC-1:0];
            default: ;
         endcase
      end
   end

   assign upio_dir_o = dir_q;
   assign upio_out_o = out_q;

   // Two-flop synchroniser ahead of the filter; prev trails filt by one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= upio_in_i;
         s2   <= s1;
         prev <= filt;
      end
   end

`ifdef UPIO_DEBOUNCE_EN
   logic [DB_CNT_W-1:0] db_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         db_q <= '0;
      else if (wr && reg_sel == REG_DEBOUNCE)
         db_q <= pwdata[DB_CNT_W-1:0];
   end

   for (genvar i = 0; i < NUM_IO; i++) begin : g_db
      upio_debounce #(.DB_CNT_W(DB_CNT_W)) u_db (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .din    (s2[i]),
         .db_val (db_q),
         .dout   (filt[i])
      );
   end
`else
   logic [DB_CNT_W-1:0] db_unused;
   assign db_unused = '0;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         filt <= '0;
      else
         filt <= s2;
   end
`endif

   assign rise = filt & ~prev;
   assign fall = ~filt & prev;
   assign ev   = (rise & rise_en_q) | (fall & fall_en_q);
   assign clr  = (wr && reg_sel == REG_STATUS) ? pwdata[NUM_IO-1:0] : '0;

   // New events are ORed in after the clear so a colliding set survives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         status_q <= '0;
         int_o    <= 1'b0;
      end else begin
         status_q <= (status_q & ~clr) | ev;
         int_o    <= (|status_q) | (|(src_int_i & mask_q));
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_DIR:      rdata[NUM_IO-1:0]  = dir_q;
         REG_OUT:      rdata[NUM_IO-1:0]  = out_q;
         REG_IN:       rdata[NUM_IO-1:0]  = filt;
         REG_RISE_EN:  rdata[NUM_IO-1:0]  = rise_en_q;
         REG_FALL_EN:  rdata[NUM_IO-1:0]  = fall_en_q;
         REG_STATUS:   rdata[NUM_IO-1:0]  = status_q;
         REG_SRC_MASK: rdata[NUM_SRC-1:0] = mask_q;
         REG_SRC_RAW:  rdata[NUM_SRC-1:0] = src_int_i;
`ifdef UPIO_DEBOUNCE_EN
         REG_DEBOUNCE: rdata[DB_CNT_W-1:0] = db_q;
`endif
         default:      rdata = '0;
      endcase
   end

   assign apb.PRDATA  = (access && mapped) ? rdata : '0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = access & ~mapped;

endmodule

// File: tb/tb_upio_apb_ctrl.sv
// Self-checking bench for upio_apb_ctrl; APB read expectations go through a scoreboard queue.
module tb_upio_apb_ctrl;
   import upio_pkg::*;

   localparam int NUM_IO  = 8;
   localparam int NUM_SRC = 2;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [NUM_IO-1:0]  upio_in_i, upio_out_o, upio_dir_o;
   logic [NUM_SRC-1:0] src_int_i;
   logic               int_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   upio_apb_if #(.ADDR_W(12)) apb ();

   upio_apb_ctrl #(.NUM_IO(NUM_IO), .NUM_SRC(NUM_SRC), .ADDR_W(12), .DB_CNT_W(16)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .apb        (apb),
      .upio_in_i  (upio_in_i),
      .upio_out_o (upio_out_o),
      .upio_dir_o (upio_dir_o),
      .src_int_i  (src_int_i),
      .int_o      (int_o)
   );

   always #5 clk_i = ~clk_i;

   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      apb.PADDR = {4'h0, a}; apb.PWDATA = d; apb.PWRITE = 1'b1;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      tick(1);
      apb.PENABLE = 1'b1;
      tick(1);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      apb.PADDR = {4'h0, a}; apb.PWRITE = 1'b0;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      tick(1);
      apb.PENABLE = 1'b1;
      #2;
      d = apb.PRDATA;
      e = apb.PSLVERR;
      tick(1);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0]  addrs[$];
      logic [31:0] d;
      logic        e;
      exp_t        x;
      rst_i = 1'b1;
      tick(3);
      rst_i = 1'b0;
      tick(1);
      checks++;
      if (upio_out_o !== '0 || upio_dir_o !== '0 || int_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs out=%h dir=%h int=%b expected all 0", upio_out_o, upio_dir_o, int_o);
      end
      addrs = '{UPIO_DIR, UPIO_OUT, UPIO_IN, UPIO_RISE_EN, UPIO_FALL_EN, UPIO_STATUS, UPIO_SRC_MASK, UPIO_SRC_RAW};
      foreach (addrs[i]) exp_q.push_back('{32'h0, 1'b0});
      foreach (addrs[i]) begin
         apb_read(addrs[i], d, e);
         x = exp_q.pop_front();
         checks++;
         if (d !== x.data || e !== x.err) begin
            errors++;
            $display("FAIL reset_read @%h got %h/%b expected %h/%b", addrs[i], d, e, x.data, x.err);
         end
      end
   endtask

   task automatic test_dir_out();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      apb_write(UPIO_DIR, 32'hA5);
      apb_write(UPIO_OUT, 32'hFF);
      checks++;
      if (upio_dir_o !== 8'hA5 || upio_out_o !== 8'hFF) begin
         errors++;
         $display("FAIL dir_out_pins dir=%h out=%h expected a5/ff", upio_dir_o, upio_out_o);
      end
      exp_q.push_back('{32'hA5, 1'b0});
      apb_read(UPIO_DIR, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err) begin
         errors++; $display("FAIL dir_read got %h expected %h", d, x.data);
      end
      exp_q.push_back('{32'hFF, 1'b0});
      apb_read(UPIO_OUT, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err) begin
         errors++; $display("FAIL out_read got %h expected %h", d, x.data);
      end
      // Bits above NUM_IO are dropped on write and read back as 0.
      apb_write(UPIO_DIR, 32'hFFFF_FFFF);
      exp_q.push_back('{32'hFF, 1'b0});
      apb_read(UPIO_DIR, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL dir_upper_bits got %h expected %h", d, x.data);
      end
   endtask

   task automatic test_rise_irq();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      logic        iexp[$];
      apb_write(UPIO_RISE_EN, 32'h01);
      tick(1);
      // Continuous read of STATUS to watch the exact edge it sets on.
      apb.PADDR = {4'h0, UPIO_STATUS}; apb.PWRITE = 1'b0;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b1;
      upio_in_i[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         exp_q.push_back('{(k >= 4) ? 32'h1 : 32'h0, 1'b0});
         iexp.push_back(k >= 5);
      end
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         x = exp_q.pop_front();
         checks++;
         if (apb.PRDATA !== x.data || int_o !== iexp.pop_front()) begin
            errors++;
            $display("FAIL rise_latency edge%0d status=%h int=%b expected status=%h", k, apb.PRDATA, int_o, x.data);
         end
      end
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
      apb_write(UPIO_STATUS, 32'h01);
      checks++;
      if (int_o !== 1'b1) begin
         errors++; $display("FAIL w1c_int_hold got %b expected 1", int_o);
      end
      tick(1);
      checks++;
      if (int_o !== 1'b0) begin
         errors++; $display("FAIL w1c_int_low got %b expected 0", int_o);
      end
      exp_q.push_back('{32'h0, 1'b0});
      apb_read(UPIO_STATUS, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL w1c_status got %h expected %h", d, x.data);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      apb_write(UPIO_FALL_EN, 32'h04);
      upio_in_i[2] = 1'b1;
      tick(6);
      upio_in_i[2] = 1'b0;
      tick(2);
      apb.PADDR = {4'h0, UPIO_STATUS}; apb.PWDATA = 32'h04; apb.PWRITE = 1'b1;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      tick(1);
      apb.PENABLE = 1'b1;
      tick(1);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      exp_q.push_back('{32'h04, 1'b0});
      apb_read(UPIO_STATUS, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL collision_set_wins got %h expected %h", d, x.data);
      end
      apb_write(UPIO_STATUS, 32'h04);
      exp_q.push_back('{32'h0, 1'b0});
      apb_read(UPIO_STATUS, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL collision_clear got %h expected %h", d, x.data);
      end
   endtask

   task automatic test_edge_modes();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      // Pin already high when enabled: no status.
      upio_in_i[1] = 1'b1;
      tick(6);
      apb_write(UPIO_RISE_EN, 32'h02);
      tick(4);
      exp_q.push_back('{32'h0, 1'b0});
      apb_read(UPIO_STATUS, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL enable_while_high got %h expected %h", d, x.data);
      end
      exp_q.push_back('{32'h03, 1'b0});
      apb_read(UPIO_IN, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL in_read got %h expected %h", d, x.data);
      end
      apb_write(UPIO_RISE_EN, 32'h08);
      apb_write(UPIO_FALL_EN, 32'h08);
      for (int t = 0; t < 2; t++) begin
         upio_in_i[3] = ~upio_in_i[3];
         tick(6);
         exp_q.push_back('{32'h08, 1'b0});
         apb_read(UPIO_STATUS, d, e);
         x = exp_q.pop_front();
         checks++;
         if (d !== x.data) begin
            errors++; $display("FAIL both_edges toggle%0d got %h expected %h", t, d, x.data);
         end
         apb_write(UPIO_STATUS, 32'hFF);
      end
   endtask

   task automatic test_ext_src();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      src_int_i = 2'b10;
      tick(3);
      checks++;
      if (int_o !== 1'b0) begin
         errors++; $display("FAIL src_masked got %b expected 0", int_o);
      end
      apb_write(UPIO_SRC_MASK, 32'h2);
      checks++;
      if (int_o !== 1'b0) begin
         errors++; $display("FAIL src_mask_commit got %b expected 0", int_o);
      end
      tick(1);
      checks++;
      if (int_o !== 1'b1) begin
         errors++; $display("FAIL src_unmasked got %b expected 1", int_o);
      end
      exp_q.push_back('{32'h2, 1'b0});
      apb_read(UPIO_SRC_RAW, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL src_raw got %h expected %h", d, x.data);
      end
      src_int_i = 2'b00;
      tick(2);
      checks++;
      if (int_o !== 1'b0) begin
         errors++; $display("FAIL src_release got %b expected 0", int_o);
      end
   endtask

   task automatic test_error();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      apb_write(8'h3C, 32'hFFFF_FFFF);
      exp_q.push_back('{32'h0, 1'b1});
      apb_read(8'h3C, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err) begin
         errors++; $display("FAIL unmapped_read got %h/%b expected %h/%b", d, e, x.data, x.err);
      end
      exp_q.push_back('{32'hFF, 1'b0});
      apb_read(UPIO_OUT, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err) begin
         errors++; $display("FAIL unmapped_no_change got %h/%b expected %h/%b", d, e, x.data, x.err);
      end
   endtask

`ifdef UPIO_DEBOUNCE_EN
   task automatic test_debounce();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      apb_write(UPIO_DEBOUNCE, 32'h4);
      apb_write(UPIO_RISE_EN, 32'h10);
      upio_in_i[4] = 1'b1;
      tick(3);
      upio_in_i[4] = 1'b0;
      tick(12);
      exp_q.push_back('{32'h03, 1'b0});
      exp_q.push_back('{32'h00, 1'b0});
      apb_read(UPIO_IN, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL db_glitch_in got %h expected %h", d, x.data);
      end
      apb_read(UPIO_STATUS, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL db_glitch_status got %h expected %h", d, x.data);
      end
      upio_in_i[4] = 1'b1;
      tick(6);
      upio_in_i[4] = 1'b0;
      tick(2);
      exp_q.push_back('{32'h13, 1'b0});
      exp_q.push_back('{32'h10, 1'b0});
      apb_read(UPIO_IN, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL db_pulse_in got %h expected %h", d, x.data);
      end
      apb_read(UPIO_STATUS, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data) begin
         errors++; $display("FAIL db_pulse_status got %h expected %h", d, x.data);
      end
   endtask
`else
   task automatic test_debounce();
      logic [31:0] d;
      logic        e;
      exp_t        x;
      exp_q.push_back('{32'h0, 1'b1});
      apb_read(UPIO_DEBOUNCE, d, e);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err) begin
         errors++; $display("FAIL db_unmapped got %h/%b expected %h/%b", d, e, x.data, x.err);
      end
   endtask
`endif

   initial begin
      rst_i       = 1'b1;
      upio_in_i   = '0;
      src_int_i   = '0;
      apb.PADDR   = '0;
      apb.PWDATA  = '0;
      apb.PWRITE  = 1'b0;
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      tick(1);
      test_reset();
      test_dir_out();
      test_rise_irq();
      test_collision();
      test_edge_modes();
      test_ext_src();
      test_error();
      test_debounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
